fetch_sequencer: RTL and testbench

//  Multi-cycle sequencer upstream of the control unit. Owns the PC, instruction register (IR) and memory data register (MDR).

---
 rtl/fetch_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle sequencer in front of the control unit.
// Owns PC, IR and MDR, drives the single-port unified memory for instruction fetch and LD/ST,
// exposes IR fields to the control unit and turns its level decode outputs into single-cycle
// strobes for the regfile, memory and PC.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   mem_req/mem_we/mem_addr         memory request, write qualifier, word address
//   mem_rdata/mem_ready             read data and access-complete handshake
//   opcode/rd/rs/rt/imm9            IR fields for the control unit
//   cu_*                            control unit decode levels
//   alu_zero/alu_result             BEQZ condition and LD/ST effective address
//   reg_we                          one-cycle regfile write strobe
//   wb_mem_data                     MDR contents for mem-to-reg writeback
//   pc, halted, err_timeout         current PC, sticky halt, sticky memory-timeout fault
//
// Optional feature macro SEQ_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W         = 16,
  parameter int unsigned       DATA_W         = 16,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int unsigned       TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [3:0]        opcode,
  output logic [2:0]        rd,
  output logic [2:0]        rs,
  output logic [2:0]        rt,
  output logic [8:0]        imm9,
  input  logic              cu_reg_we,
  input  logic              cu_mem_we,
  input  logic              cu_mem_sel,
  input  logic              cu_jump,
  input  logic              cu_branch,
  input  logic              cu_halt,
  input  logic              alu_zero,
  input  logic [ADDR_W-1:0] alu_result,
  output logic              reg_we,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err_timeout
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  localparam int unsigned     TmoW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              err_q, err_d;
  // Low for the first cycle after reset so mem_req only rises once reset is released.
  logic              run_q;

  logic [ADDR_W-1:0] pc_inc, imm_zext, imm_sext;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign imm_zext = {{(ADDR_W - 9){1'b0}}, ir_q[8:0]};
  assign imm_sext = {{(ADDR_W - 9){ir_q[8]}}, ir_q[8:0]};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    reg_we   = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req  = run_q;
        mem_addr = pc_q;
        if (run_q && mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_inc;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = cu_halt ? StHalt : StExec;
      end
      StExec: begin
        tmo_d = '0;
        if (cu_mem_sel) begin
          state_d = StMem;
        end else begin
          reg_we  = cu_reg_we;
          state_d = StFetch;
          // Jump has priority over branch; pc already points past the branch.
          if (cu_jump) begin
            pc_d = imm_zext;
          end else if (cu_branch && alu_zero) begin
            pc_d = pc_q + imm_sext;
          end
        end
      end
      StMem: begin
        mem_req  = 1'b1;
        mem_addr = alu_result;
        mem_we   = cu_mem_we;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          tmo_d   = '0;
          state_d = cu_mem_we ? StFetch : StWb;
        end
      end
      StWb: begin
        reg_we  = cu_reg_we;
        tmo_d   = '0;
        state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase

    // Memory stall watchdog: counts only cycles where a request is outstanding.
    if (mem_req && !mem_ready) begin
      if (tmo_q == TmoLast) begin
        state_d = StHalt;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  assign opcode      = ir_q[15:12];
  assign rd          = ir_q[11:9];
  assign rs          = ir_q[8:6];
  assign rt          = ir_q[5:3];
  assign imm9        = ir_q[8:0];
  assign wb_mem_data = mdr_q;
  assign pc          = pc_q;
  assign halted      = (state_q == StHalt);
  assign err_timeout = err_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;
  logic        ret_fetch;

  assign ret_fetch = (state_d == StFetch) && (state_q != StFetch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != StHalt) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (ret_fetch)         instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: acts as unified memory and control unit, runs a directed
// prologue followed by a random program, and scoreboards every memory handshake and regfile
// strobe against an instruction-level reference model. Directed phases cover HLT, reset
// during a memory access and the memory timeout.
module tb_fetch_sequencer;

  localparam int EvFetch = 0;
  localparam int EvData  = 1;
  localparam int EvReg   = 2;

  typedef struct {
    int kind;
    int addr;
    int we;
    int lat;
    int data;
    bit chk;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_rdata;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs, rt;
  logic [8:0]  imm9;
  logic        cu_reg_we, cu_mem_we, cu_mem_sel, cu_jump, cu_branch, cu_halt;
  logic        alu_zero;
  logic [15:0] alu_result;
  logic        reg_we, halted, err_timeout;
  logic [15:0] wb_mem_data, pc;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  logic [15:0] mem [0:65535];
  ev_t         sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          strict   = 1'b0;
  bit          tmo_mode = 1'b0;
  bit          stall_en = 1'b0;

  fetch_sequencer #(
    .ADDR_W        (16),
    .DATA_W        (16),
    .RESET_PC      (16'hFFFF),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .opcode     (opcode),
    .rd         (rd),
    .rs         (rs),
    .rt         (rt),
    .imm9       (imm9),
    .cu_reg_we  (cu_reg_we),
    .cu_mem_we  (cu_mem_we),
    .cu_mem_sel (cu_mem_sel),
    .cu_jump    (cu_jump),
    .cu_branch  (cu_branch),
    .cu_halt    (cu_halt),
    .alu_zero   (alu_zero),
    .alu_result (alu_result),
    .reg_we     (reg_we),
    .wb_mem_data(wb_mem_data),
    .pc         (pc),
    .halted     (halted),
    .err_timeout(err_timeout)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bench control unit: {reg_we, mem_we, mem_sel, jump, branch, halt}.
  function automatic logic [5:0] cu_dec(input logic [3:0] op);
    case (op)
      4'd1:    return 6'b100000;  // ADD
      4'd2:    return 6'b101000;  // LD
      4'd3:    return 6'b011000;  // ST
      4'd4:    return 6'b000100;  // JMP
      4'd5:    return 6'b000010;  // BEQZ
      4'd6:    return 6'b000110;  // jump and branch together
      4'd7:    return 6'b111000;  // store with reg_we set: no writeback expected
      4'd8:    return 6'b001000;  // load without writeback
      4'd14:   return 6'b000001;  // HLT
      default: return 6'b000000;
    endcase
  endfunction

  assign {cu_reg_we, cu_mem_we, cu_mem_sel, cu_jump, cu_branch, cu_halt} = cu_dec(opcode);
  assign alu_zero   = rd[0];
  assign alu_result = {7'd0, imm9};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input int we, input int lat,
                         input int data, input bit chk);
    ev_t e;
    e.kind = kind; e.addr = addr; e.we = we; e.lat = lat; e.data = data; e.chk = chk;
    sb_q.push_back(e);
  endtask

  // Instruction-level model: walks the program and lists the expected bus/strobe events,
  // with each fetch carrying the zero-wait cycle count of the previous instruction.
  task automatic run_model(input int n_instr);
    int pc_m = 16'hFFFF;
    int base = 0;
    for (int i = 0; i <= n_instr; i++) begin
      logic [15:0] w;
      logic [5:0]  cu;
      int          npc, imm, ea;
      w = mem[pc_m];
      push_ev(EvFetch, pc_m, 0, base, 0, 1'b0);
      if (i == n_instr) break;
      cu  = cu_dec(w[15:12]);
      npc = (pc_m + 1) % 65536;
      imm = int'(w[8:0]);
      if (cu[3]) begin
        ea = imm;
        push_ev(EvData, ea, int'(cu[4]), 0, 0, 1'b0);
        if (cu[4]) begin
          base = 4;
        end else begin
          base = 5;
          if (cu[5]) push_ev(EvReg, 0, 0, 0, int'(mem[ea]), 1'b1);
        end
      end else begin
        base = 3;
        if (cu[5]) push_ev(EvReg, 0, 0, 0, 0, 1'b0);
        if (cu[2]) npc = imm;
        else if (cu[1] && w[9]) npc = (npc + (imm >= 256 ? imm - 512 : imm) + 65536) % 65536;
      end
      pc_m = npc;
    end
  endtask

  // Memory responder: random 0..3 wait states per access, decided just after each edge.
  initial begin
    int wcnt = -1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !mem_req || tmo_mode) begin
        mem_ready = 1'b0;
        wcnt      = -1;
      end else begin
        if (mem_ready) wcnt = -1;
        if (stall_en && mem_addr == 16'h0040) begin
          mem_ready = 1'b0;
        end else begin
          if (wcnt < 0) wcnt = $urandom_range(0, 3);
          if (wcnt == 0) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
          end else begin
            mem_ready = 1'b0;
            wcnt--;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every memory handshake and every reg_we strobe.
  initial begin
    int  since = 0;
    int  waits = 0;
    bit  have_prev = 1'b0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        since = 0; waits = 0; have_prev = 1'b0;
      end else begin
        since++;
        if (mem_req && mem_ready) begin
          if (sb_q.size() == 0) begin
            if (strict) check("unexpected_mem", int'(mem_addr), -1);
          end else begin
            e = sb_q.pop_front();
            check("ev_is_mem", 1, int'(e.kind != EvReg));
            check("mem_addr", int'(mem_addr), e.addr);
            check("mem_we", int'(mem_we), e.we);
            if (e.kind == EvFetch) begin
              check("fetch_pc", int'(pc), e.addr);
              if (have_prev && e.lat != 0) check("latency", since, e.lat + waits);
              since = 0; waits = 0; have_prev = 1'b1;
            end
          end
        end else if (mem_req) begin
          waits++;
        end
        if (reg_we) begin
          if (sb_q.size() == 0) begin
            if (strict) check("unexpected_reg_we", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("ev_is_reg", 1, int'(e.kind == EvReg));
            if (e.chk) check("wb_mem_data", int'(wb_mem_data), e.data);
          end
        end
      end
    end
  end

  initial begin
    int  n_req;
    bit  seen, dropped;
    int  op;
    rst_n = 1'b0;

    // Program: directed prologue then random, HLT-free words.
    for (int a = 0; a < 65536; a++) begin
      do op = $urandom_range(0, 15); while (op == 14);
      mem[a] = {op[3:0], 12'($urandom)};
    end
    mem[16'hFFFF] = 16'h1250;  // ADD, pc wraps to 0
    mem[16'h0000] = 16'h4005;  // JMP 5
    mem[16'h0005] = 16'h53FC;  // BEQZ taken, -4 -> 0x0002
    mem[16'h0002] = 16'h2040;  // LD from 0x0040
    mem[16'h0040] = 16'hBEEF;
    mem[16'h0003] = 16'h4123;  // JMP 0x123
    mem[16'h0123] = 16'h51FC;  // BEQZ not taken -> 0x0124
    mem[16'h0124] = 16'h3010;  // ST to 0x0010
    mem[16'h0125] = 16'h6007;  // jump wins over branch -> 0x0007
    run_model(200);

    repeat (3) @(negedge clk);
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_reg_we", int'(reg_we), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_err", int'(err_timeout), 0);
    check("rst_pc", int'(pc), 16'hFFFF);
    check("rst_opcode", int'(opcode), 0);
    check("rst_mdr", int'(wb_mem_data), 0);

    // Random program run.
    strict = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    check("program_drained", sb_q.size(), 0);
    strict = 1'b0;
    check("run_halted", int'(halted), 0);
    check("run_err", int'(err_timeout), 0);
    rst_n = 1'b0;
    sb_q.delete();

    // HLT: one fetch, then halted with no further requests.
    @(negedge clk);
    mem[16'hFFFF] = 16'hE000;
    push_ev(EvFetch, 16'hFFFF, 0, 0, 0, 1'b0);
    strict = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("hlt_halted", int'(halted), 1);
    check("hlt_sb_empty", sb_q.size(), 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    check("hlt_no_req", int'(seen), 0);
    check("hlt_err", int'(err_timeout), 0);

    // Reset asserted while a LD is stalled in MEM.
    rst_n = 1'b0;
    @(negedge clk);
    mem[16'hFFFF] = 16'h2040;
    stall_en = 1'b1;
    push_ev(EvFetch, 16'hFFFF, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 16'h0040) begin
        seen = 1'b1;
        break;
      end
    end
    check("mem_phase_seen", int'(seen), 1);
    check("ld_mem_we", int'(mem_we), 0);
    check("ld_opcode", int'(opcode), 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", int'(mem_req), 0);
    check("arst_pc", int'(pc), 16'hFFFF);
    check("arst_opcode", int'(opcode), 0);
    check("arst_reg_we", int'(reg_we), 0);
    check("arst_halted", int'(halted), 0);
    check("arst_sb_empty", sb_q.size(), 0);
    strict   = 1'b0;
    stall_en = 1'b0;

    // Timeout: memory never answers.
    tmo_mode = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    n_req   = 0;
    seen    = 1'b0;
    dropped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req) begin
        n_req++;
        seen = 1'b1;
      end else if (seen) begin
        dropped = 1'b1;
        break;
      end
    end
    check("tmo_dropped", int'(dropped), 1);
    check("tmo_req_cycles", n_req, 8);
    check("tmo_halted", int'(halted), 1);
    check("tmo_err", int'(err_timeout), 1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    check("tmo_no_req", int'(seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
